game_sequencer: RTL and testbench
=================================

# game_sequencer

Central game-flow controller for the Flappy VGA design. It replaces the raw button wiring into the pipe RAM, obstacle logic and flight physics. It debounces the player buttons and runs the Idle/Run/Lose state machine. It turns the per-frame tick from the sync generator into single-cycle step enables for the pipe and bird datapaths, and it keeps a high score across rounds.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a button level is accepted; counter width 20 bits.
- PIPE_DIV, 1: frames per Pipe_Step; range 1..15.
- BIRD_DIV, 2: frames per Bird_Step; range 1..15.
- FLASH_DIV, 16: frames per Flash toggle in LOSE; range 1..63.

Ports:
- Clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- BtnStart  in  1  raw start/acknowledge button, asynchronous.
- BtnJump  in  1  raw jump button, asynchronous.
- Frame_Tick  in  1  one-cycle pulse per video frame, synchronous to Clk.
- Collide  in  1  level from obstacle logic: bird overlaps a pipe or a screen edge.
- Score  in  4  current round score from the pipe RAM.
- Clear  out  1  one-cycle pulse that reinitialises the pipe and bird datapaths.
- Pipe_Step  out  1  one-cycle pipe-advance enable.
- Bird_Step  out  1  one-cycle physics-update enable.
- Jump_Pulse  out  1  one-cycle debounced jump.
- Q_Idle, Q_Run, Q_Lose  out  1 each  one-hot state flags.
- Flash  out  1  lose-screen blue flash level.
- High_Score  out  4  best score since reset.

## Operation
- Input conditioning: each button passes through a 2-FF synchroniser, then a debouncer.
  - The debouncer counter clears whenever the synchronised level equals the accepted level.
  - When the counter reaches DEBOUNCE_CYCLES-1, the accepted level takes the synchronised value.
  - A 0→1 change of the accepted level produces a one-cycle internal press pulse (start_p, jump_p).
- States: IDLE, ARM, RUN, LOSE.
  - IDLE: on start_p → ARM.
  - ARM: on the next Frame_Tick → RUN. The counters load PIPE_DIV-1 and BIRD_DIV-1, and no step is emitted on that tick.
  - RUN, on Frame_Tick:
    - Each frame counter decrements.
    - A counter at 0 emits its step pulse in the same cycle and reloads DIV-1.
  - RUN, on Collide=1 → LOSE. In the same cycle, High_Score ← Score if Score > High_Score.
  - RUN: start_p is ignored.
  - LOSE: Flash toggles each FLASH_DIV frames (frame counter, 6 bits). On start_p → IDLE, Clear pulses for one cycle, and Flash ← 0.
- Jump_Pulse equals jump_p gated by RUN. Presses in IDLE, ARM or LOSE are dropped, not queued.
- Collide is ignored outside RUN.
- Simultaneous events:
  - Collide and Frame_Tick in the same RUN cycle: Collide wins. No step pulses are emitted and the state goes to LOSE.
  - Collide and jump_p in the same cycle: Jump_Pulse is suppressed.
- Score is treated as unsigned 4-bit. The comparison uses strictly greater-than, so equal scores do not rewrite High_Score.

## Timing
- Reset values (asynchronous, on reset_n=0):
  - State IDLE, so Q_Idle=1 and all other flags 0.
  - Clear=1 while reset_n is low, then 0 after the first Clk edge with reset_n high.
  - Pipe_Step, Bird_Step, Jump_Pulse, Flash all 0.
  - High_Score=0.
  - All counters 0; debouncer accepted levels 0.
- Button latency from a raw edge to the press pulse: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles, provided the input stays stable.
- Step pulses are registered and appear one cycle after the Frame_Tick that causes them.
- State flags change one cycle after the triggering input.
- Clear asserts in the cycle the state register becomes IDLE.
- Mid-round reset aborts immediately. No steps are emitted and High_Score is lost.

## Configuration
- HIGH_SCORE_EN defined: High_Score register and comparator are present as described.
- Undefined: High_Score is tied to 4'd0 and the comparator is removed; everything else is unchanged.

## Test plan
Bench settings: DEBOUNCE_CYCLES=4, PIPE_DIV=1, BIRD_DIV=2, FLASH_DIV=2; Frame_Tick every 20 cycles.
- Reset, then pulse BtnStart high for 3 cycles only → no state change; Q_Idle stays 1.
- Hold BtnStart high → Q_Idle falls 7 cycles after the raw edge (ARM). The next Frame_Tick gives Q_Run=1 and no steps.
- In RUN, 4 Frame_Ticks → 4 Pipe_Step pulses and 2 Bird_Step pulses, each one cycle after its tick.
- Score=5, Collide=1 in the same cycle as Frame_Tick → no step pulse, Q_Lose=1, High_Score=5. Flash toggles every 2 frames.
- In LOSE, press BtnStart → Q_Idle=1 with a single-cycle Clear. A new round ending at Score=3 leaves High_Score=5.
- BtnJump pressed in IDLE → no Jump_Pulse. Pressed in RUN → exactly one Jump_Pulse per press. reset_n low mid-RUN → all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : game_sequencer
// Purpose  : Flappy VGA game-flow controller. Debounces the start and jump
//            buttons, runs the IDLE/ARM/RUN/LOSE flow, divides Frame_Tick
//            into pipe/bird step enables and keeps the lose-screen flash.
// Options  : HIGH_SCORE_EN - when defined, keeps the best score since reset;
//            otherwise High_Score is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module game_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PIPE_DIV        = 1,
  parameter int BIRD_DIV        = 2,
  parameter int FLASH_DIV       = 16
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       BtnStart,
  input  logic       BtnJump,
  input  logic       Frame_Tick,
  input  logic       Collide,
  input  logic [3:0] Score,
  output logic       Clear,
  output logic       Pipe_Step,
  output logic       Bird_Step,
  output logic       Jump_Pulse,
  output logic       Q_Idle,
  output logic       Q_Run,
  output logic       Q_Lose,
  output logic       Flash,
  output logic [3:0] High_Score
);

  localparam logic [19:0] C_DEB_LAST     = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]  C_PIPE_RELOAD  = 4'(PIPE_DIV - 1);
  localparam logic [3:0]  C_BIRD_RELOAD  = 4'(BIRD_DIV - 1);
  localparam logic [5:0]  C_FLASH_RELOAD = 6'(FLASH_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_LOSE = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Button conditioning: bit 0 = start, bit 1 = jump
  // ---------------------------------------------------------------------------
  logic [1:0] w_btn_raw;
  logic [1:0] w_press;
  assign w_btn_raw = {BtnJump, BtnStart};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic        sync1_q;
    logic        sync2_q;
    logic        acc_q;
    logic        prev_q;
    logic [19:0] cnt_q;

    // Two-flop synchroniser, stability counter and accepted-level tracking
    always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        acc_q   <= 1'b0;
        prev_q  <= 1'b0;
        cnt_q   <= 20'd0;
      end else begin
        sync1_q <= w_btn_raw[gi];
        sync2_q <= sync1_q;
        prev_q  <= acc_q;
        if (sync2_q == acc_q) begin
          cnt_q <= 20'd0;
        end else if (cnt_q == C_DEB_LAST) begin
          acc_q <= sync2_q;
          cnt_q <= 20'd0;
        end else begin
          cnt_q <= cnt_q + 20'd1;
        end
      end
    end

    // Rising edge of the accepted level is the press pulse
    assign w_press[gi] = acc_q & ~prev_q;
  end

  logic w_start_p;
  logic w_jump_p;
  assign w_start_p = w_press[0];
  assign w_jump_p  = w_press[1];

  // ---------------------------------------------------------------------------
  // Game flow state machine and frame dividers
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [3:0] pipe_cnt_q, pipe_cnt_d;
  logic [3:0] bird_cnt_q, bird_cnt_d;
  logic [5:0] flash_cnt_q, flash_cnt_d;
  logic       flash_q, flash_d;
  logic       pipe_step_q, pipe_step_d;
  logic       bird_step_q, bird_step_d;
  logic       clear_q, clear_d;
  logic       w_new_best;

`ifdef HIGH_SCORE_EN
  logic [3:0] hs_q, hs_d;
  assign w_new_best = (Score > hs_q);
`else
  logic w_unused_score;
  assign w_unused_score = ^Score;
  assign w_new_best     = 1'b0;
`endif

  // Next-state, divider and step-enable decode
  always_comb begin
    state_d     = state_q;
    pipe_cnt_d  = pipe_cnt_q;
    bird_cnt_d  = bird_cnt_q;
    flash_cnt_d = flash_cnt_q;
    flash_d     = flash_q;
    pipe_step_d = 1'b0;
    bird_step_d = 1'b0;
    clear_d     = 1'b0;
`ifdef HIGH_SCORE_EN
    hs_d        = hs_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (w_start_p) state_d = S_ARM;
      end
      S_ARM: begin
        // First tick only aligns the dividers to the frame; no step yet
        if (Frame_Tick) begin
          state_d    = S_RUN;
          pipe_cnt_d = C_PIPE_RELOAD;
          bird_cnt_d = C_BIRD_RELOAD;
        end
      end
      S_RUN: begin
        // A collision takes priority over any step on the same tick
        if (Collide) begin
          state_d     = S_LOSE;
          flash_cnt_d = C_FLASH_RELOAD;
          flash_d     = 1'b0;
`ifdef HIGH_SCORE_EN
          if (w_new_best) hs_d = Score;
`endif
        end else if (Frame_Tick) begin
          if (pipe_cnt_q == 4'd0) begin
            pipe_step_d = 1'b1;
            pipe_cnt_d  = C_PIPE_RELOAD;
          end else begin
            pipe_cnt_d  = pipe_cnt_q - 4'd1;
          end
          if (bird_cnt_q == 4'd0) begin
            bird_step_d = 1'b1;
            bird_cnt_d  = C_BIRD_RELOAD;
          end else begin
            bird_cnt_d  = bird_cnt_q - 4'd1;
          end
        end
      end
      S_LOSE: begin
        if (w_start_p) begin
          state_d = S_IDLE;
          clear_d = 1'b1;
          flash_d = 1'b0;
        end else if (Frame_Tick) begin
          if (flash_cnt_q == 6'd0) begin
            flash_d     = ~flash_q;
            flash_cnt_d = C_FLASH_RELOAD;
          end else begin
            flash_cnt_d = flash_cnt_q - 6'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, divider and registered-output flops; Clear is held during reset
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      pipe_cnt_q  <= 4'd0;
      bird_cnt_q  <= 4'd0;
      flash_cnt_q <= 6'd0;
      flash_q     <= 1'b0;
      pipe_step_q <= 1'b0;
      bird_step_q <= 1'b0;
      clear_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      pipe_cnt_q  <= pipe_cnt_d;
      bird_cnt_q  <= bird_cnt_d;
      flash_cnt_q <= flash_cnt_d;
      flash_q     <= flash_d;
      pipe_step_q <= pipe_step_d;
      bird_step_q <= bird_step_d;
      clear_q     <= clear_d;
    end
  end

`ifdef HIGH_SCORE_EN
  // Best score since reset
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) hs_q <= 4'd0;
    else          hs_q <= hs_d;
  end
  assign High_Score = hs_q;
`else
  assign High_Score = 4'd0;
`endif

  assign Clear      = clear_q;
  assign Pipe_Step  = pipe_step_q;
  assign Bird_Step  = bird_step_q;
  assign Flash      = flash_q;
  assign Q_Idle     = (state_q == S_IDLE);
  assign Q_Run      = (state_q == S_RUN);
  assign Q_Lose     = (state_q == S_LOSE);
  // Jumps only count while flying and not on the collision cycle
  assign Jump_Pulse = w_jump_p & (state_q == S_RUN) & ~Collide;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_sequencer
// Purpose  : Directed self-checking bench for game_sequencer with
//            DEBOUNCE_CYCLES=4, PIPE_DIV=1, BIRD_DIV=2, FLASH_DIV=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_sequencer;

  logic       Clk = 1'b0;
  logic       reset_n;
  logic       BtnStart;
  logic       BtnJump;
  logic       Frame_Tick;
  logic       Collide;
  logic [3:0] Score;
  logic       Clear;
  logic       Pipe_Step;
  logic       Bird_Step;
  logic       Jump_Pulse;
  logic       Q_Idle;
  logic       Q_Run;
  logic       Q_Lose;
  logic       Flash;
  logic [3:0] High_Score;

  int checks = 0;
  int errors = 0;
  int jcount;

`ifdef HIGH_SCORE_EN
  localparam logic [3:0] C_HS5 = 4'd5;
`else
  localparam logic [3:0] C_HS5 = 4'd0;
`endif

  game_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .PIPE_DIV       (1),
    .BIRD_DIV       (2),
    .FLASH_DIV      (2)
  ) dut (
    .Clk       (Clk),
    .reset_n   (reset_n),
    .BtnStart  (BtnStart),
    .BtnJump   (BtnJump),
    .Frame_Tick(Frame_Tick),
    .Collide   (Collide),
    .Score     (Score),
    .Clear     (Clear),
    .Pipe_Step (Pipe_Step),
    .Bird_Step (Bird_Step),
    .Jump_Pulse(Jump_Pulse),
    .Q_Idle    (Q_Idle),
    .Q_Run     (Q_Run),
    .Q_Lose    (Q_Lose),
    .Flash     (Flash),
    .High_Score(High_Score)
  );

  always #5 Clk = ~Clk;

  // Advance n rising edges, then settle 1 time unit past the last one
  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle Frame_Tick; outputs caused by it are visible on return
  task automatic tick();
    Frame_Tick = 1'b1;
    cyc(1);
    Frame_Tick = 1'b0;
  endtask

  task automatic press_start();
    BtnStart = 1'b1;
    cyc(10);
    BtnStart = 1'b0;
    cyc(10);
  endtask

  task automatic press_jump_count();
    BtnJump = 1'b1;
    jcount  = 0;
    repeat (12) begin
      cyc(1);
      jcount += int'(Jump_Pulse);
    end
    BtnJump = 1'b0;
    cyc(10);
  endtask

  initial begin
    reset_n = 1'b0; BtnStart = 1'b0; BtnJump = 1'b0;
    Frame_Tick = 1'b0; Collide = 1'b0; Score = 4'd0;
    cyc(3);
    chk("reset_idle",  {3'b0, Q_Idle}, 4'd1);
    chk("reset_run",   {3'b0, Q_Run},  4'd0);
    chk("reset_lose",  {3'b0, Q_Lose}, 4'd0);
    chk("reset_clear", {3'b0, Clear},  4'd1);
    chk("reset_outs",  {Pipe_Step, Bird_Step, Jump_Pulse, Flash}, 4'd0);
    chk("reset_hs",    High_Score, 4'd0);
    reset_n = 1'b1;
    cyc(1);
    chk("clear_release", {3'b0, Clear}, 4'd0);

    // 3-cycle glitch on start is filtered out
    BtnStart = 1'b1; cyc(3); BtnStart = 1'b0; cyc(10);
    chk("glitch_idle", {3'b0, Q_Idle}, 4'd1);

    // Jump in IDLE is dropped
    press_jump_count();
    chk("idle_jump", 4'(jcount), 4'd0);

    // Held start: IDLE falls exactly 7 edges after the raw edge
    BtnStart = 1'b1;
    cyc(6);
    chk("arm_not_yet", {3'b0, Q_Idle}, 4'd1);
    cyc(1);
    chk("arm_idle_low", {3'b0, Q_Idle}, 4'd0);
    chk("arm_run_low",  {3'b0, Q_Run},  4'd0);
    BtnStart = 1'b0; cyc(10);

    // ARM -> RUN on the next frame, no steps
    cyc(18); tick();
    chk("run_entered",    {3'b0, Q_Run}, 4'd1);
    chk("arm_tick_steps", {2'b0, Pipe_Step, Bird_Step}, 4'd0);

    // Four frames: pipe every frame, bird every second frame
    for (int k = 0; k < 4; k++) begin
      cyc(18); tick();
      chk("pipe_step", {3'b0, Pipe_Step}, 4'd1);
      chk("bird_step", {3'b0, Bird_Step}, (k % 2 == 1) ? 4'd1 : 4'd0);
      cyc(1);
      chk("step_single", {2'b0, Pipe_Step, Bird_Step}, 4'd0);
    end

    // Start ignored while running
    press_start();
    chk("run_start_ignored", {3'b0, Q_Run}, 4'd1);

    // Each jump press in RUN yields exactly one pulse
    for (int k = 0; k < 2; k++) begin
      press_jump_count();
      chk("run_jump", 4'(jcount), 4'd1);
    end

    // Collide on a tick: no steps, LOSE, best score captured
    Score = 4'd5; Collide = 1'b1; Frame_Tick = 1'b1;
    cyc(1);
    Collide = 1'b0; Frame_Tick = 1'b0;
    chk("lose_entered",  {3'b0, Q_Lose}, 4'd1);
    chk("lose_run_low",  {3'b0, Q_Run},  4'd0);
    chk("collide_steps", {2'b0, Pipe_Step, Bird_Step}, 4'd0);
    chk("hs_captured",   High_Score, C_HS5);

    // Flash toggles every second frame
    for (int k = 0; k < 4; k++) begin
      cyc(18); tick();
      chk("flash", {3'b0, Flash}, (k == 1 || k == 2) ? 4'd1 : 4'd0);
    end
    Score = 4'd0;

    // Start in LOSE: back to IDLE with a single-cycle Clear
    BtnStart = 1'b1;
    cyc(6);
    chk("lose_hold",     {3'b0, Q_Lose}, 4'd1);
    chk("lose_no_clear", {3'b0, Clear},  4'd0);
    cyc(1);
    chk("back_idle",     {3'b0, Q_Idle}, 4'd1);
    chk("clear_pulse",   {3'b0, Clear},  4'd1);
    chk("flash_cleared", {3'b0, Flash},  4'd0);
    cyc(1);
    chk("clear_single",  {3'b0, Clear},  4'd0);
    BtnStart = 1'b0; cyc(10);

    // Second round ends lower: best score stays
    press_start();
    tick();
    chk("r2_run", {3'b0, Q_Run}, 4'd1);
    Score = 4'd3; Collide = 1'b1;
    cyc(1);
    Collide = 1'b0;
    chk("r2_lose", {3'b0, Q_Lose}, 4'd1);
    chk("hs_kept", High_Score, C_HS5);

    // Third round: asynchronous reset mid-run
    press_start();
    press_start();
    tick();
    cyc(18); tick();
    chk("pre_reset_pipe", {3'b0, Pipe_Step}, 4'd1);
    reset_n = 1'b0;
    #2;
    chk("areset_run",   {3'b0, Q_Run},  4'd0);
    chk("areset_idle",  {3'b0, Q_Idle}, 4'd1);
    chk("areset_pipe",  {3'b0, Pipe_Step}, 4'd0);
    chk("areset_clear", {3'b0, Clear},  4'd1);
    chk("areset_hs",    High_Score, 4'd0);
    reset_n = 1'b1;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
